ifu_fetch: RTL and testbench

Instruction fetch unit: reads the architectural PC from the PC register, issues a read to instruction memory, and hands the returned instruction to decode. It is the only writer of the PC register's wen/wData pair: it drives sequential PC+4 updates itself and applies redirects from execute. It sits between the PC register, the imem port and the decode stage.

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu_fetch.sv | 136 +++++++++++++
 tb/tb_ifu_fetch.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, reset PC and fetch constants.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Must match the PC register's own reset value.
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int unsigned PC_STEP  = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem read, registered hand-off to decode,
// sole writer of the PC register (sequential advance and execute redirects).
module ifu_fetch #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ILEN    = 32,
  parameter int unsigned PC_STEP = ifu_pkg::PC_STEP
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [XLEN-1:0]      pc,
  output logic                 pc_wen,
  output logic [XLEN-1:0]      pc_wdata,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [XLEN-1:0]      imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [ILEN-1:0]      imem_rsp_data,
  input  logic                 imem_rsp_err,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [ILEN-1:0]      inst,
  output logic [XLEN-1:0]      inst_pc,
  output logic                 inst_err,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output ifu_pkg::fetch_state_t dbg_state
);
  import ifu_pkg::*;

  // Handshakes: a transfer happens on a rising clock edge where valid && ready.
  // imem_req_valid may drop without a transfer only when a redirect withdraws it;
  // inst_valid stays high with stable inst/inst_pc/inst_err until taken or redirected.

  fetch_state_t        state_q, state_d;
  logic                kill_q, kill_d;
  logic [ILEN-1:0]     inst_q, inst_d;
  logic [XLEN-1:0]     inst_pc_q, inst_pc_d;
  logic                inst_err_q, inst_err_d;
  logic [XLEN-1:0]     redirect_target;
  logic [XLEN-1:0]     pc_next_seq;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_next_seq     = pc + XLEN'(PC_STEP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_err_q <= inst_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    kill_d         = kill_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    inst_err_d     = inst_err_q;
    pc_wen         = 1'b0;
    pc_wdata       = '0;
    imem_req_valid = 1'b0;
    imem_req_addr  = '0;
    inst_valid     = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        imem_req_valid = 1'b1;
        imem_req_addr  = pc;
        if (redirect_valid) begin
          pc_wen   = 1'b1;
          pc_wdata = redirect_target;
        end
        if (imem_req_ready) begin
          state_d = WAIT;
          // An accepted request that was already overtaken by a redirect is dead.
          kill_d  = redirect_valid;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_wen   = 1'b1;
          pc_wdata = redirect_target;
        end
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (!kill_q && !redirect_valid) begin
            inst_d     = imem_rsp_data;
            inst_pc_d  = pc;
            inst_err_d = imem_rsp_err;
            pc_wen     = 1'b1;
            pc_wdata   = pc_next_seq;
            state_d    = HOLD;
          end else begin
            state_d = REQ;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end

      HOLD: begin
        inst_valid = 1'b1;
        if (redirect_valid) begin
          pc_wen   = 1'b1;
          pc_wdata = redirect_target;
          state_d  = REQ;
        end else if (inst_ready) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign inst      = inst_q;
  assign inst_pc   = inst_pc_q;
  assign inst_err  = inst_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a behavioural PC register closing the pc/pc_wen loop.
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  logic              clock;
  logic              reset;
  logic [XLEN-1:0]   pc_reg;
  logic              pc_wen;
  logic [XLEN-1:0]   pc_wdata;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [ILEN-1:0]   imem_rsp_data;
  logic              imem_rsp_err;
  logic              inst_valid;
  logic              inst_ready;
  logic [ILEN-1:0]   inst;
  logic [XLEN-1:0]   inst_pc;
  logic              inst_err;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  fetch_state_t      dbg_state;

  int errors = 0;
  int checks = 0;

  ifu_fetch #(.XLEN(XLEN), .ILEN(ILEN), .PC_STEP(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc_reg),
    .pc_wen         (pc_wen),
    .pc_wdata       (pc_wdata),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dbg_state      (dbg_state)
  );

  // Clock / reset block and the external PC register.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (reset) pc_reg <= RESET_PC;
    else if (pc_wen) pc_reg <= pc_wdata;
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    #1;
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    checks++; if ({inst_valid, imem_req_valid, pc_wen} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b want 000", {inst_valid, imem_req_valid, pc_wen}); end
    checks++; if (inst !== '0 || inst_pc !== '0 || inst_err !== 1'b0) begin errors++; $display("FAIL reset_regs: got inst=%h pc=%h err=%b want 0", inst, inst_pc, inst_err); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== '0) begin errors++; $display("FAIL idle_after_reset: got v=%b addr=%h want 0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_seq_fetch();
    tick();
    imem_req_ready = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL seq_req0: got v=%b addr=%h want 1 80000000", imem_req_valid, imem_req_addr); end
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = NOP;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL seq_wait_req: got %b want 0", imem_req_valid); end
    checks++; if (pc_wen !== 1'b1 || pc_wdata !== 64'h8000_0004) begin errors++; $display("FAIL seq_pcw0: got wen=%b wdata=%h want 1 80000004", pc_wen, pc_wdata); end
    tick();
    imem_rsp_valid = 1'b0; inst_ready = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst !== NOP || inst_pc !== 64'h8000_0000 || inst_err !== 1'b0) begin errors++; $display("FAIL seq_inst0: got v=%b inst=%h pc=%h err=%b want 1 00000013 80000000 0", inst_valid, inst, inst_pc, inst_err); end
    checks++; if (pc_wen !== 1'b0) begin errors++; $display("FAIL seq_hold_wen: got %b want 0", pc_wen); end
    tick();
    inst_ready = 1'b0; imem_req_ready = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0 || imem_req_addr !== 64'h8000_0004) begin errors++; $display("FAIL seq_req1: got iv=%b addr=%h want 0 80000004", inst_valid, imem_req_addr); end
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    #1;
    checks++; if (pc_wen !== 1'b1 || pc_wdata !== 64'h8000_0008) begin errors++; $display("FAIL seq_pcw1: got wen=%b wdata=%h want 1 80000008", pc_wen, pc_wdata); end
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 64'h8000_0004) begin errors++; $display("FAIL seq_inst1: got v=%b inst=%h pc=%h want 1 00100093 80000004", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 64'h8000_0004) begin errors++; $display("FAIL stall_stable[%0d]: got v=%b inst=%h pc=%h want 1 00100093 80000004", i, inst_valid, inst, inst_pc); end
      checks++; if (imem_req_valid !== 1'b0 || pc_wen !== 1'b0) begin errors++; $display("FAIL stall_quiet[%0d]: got req=%b wen=%b want 0 0", i, imem_req_valid, pc_wen); end
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0008) begin errors++; $display("FAIL rdw_req: got v=%b addr=%h want 1 80000008", imem_req_valid, imem_req_addr); end
    tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_1003;
    #1;
    checks++; if (pc_wen !== 1'b1 || pc_wdata !== 64'h8000_1000) begin errors++; $display("FAIL rdw_pcw: got wen=%b wdata=%h want 1 80001000", pc_wen, pc_wdata); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || pc_wen !== 1'b0 || dbg_state !== WAIT) begin errors++; $display("FAIL rdw_still_wait: got req=%b wen=%b st=%0d want 0 0 %0d", imem_req_valid, pc_wen, dbg_state, WAIT); end
    tick();
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    #1;
    checks++; if (pc_wen !== 1'b0) begin errors++; $display("FAIL rdw_killed_wen: got %b want 0", pc_wen); end
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000) begin errors++; $display("FAIL rdw_next_req: got iv=%b req=%b addr=%h want 0 1 80001000", inst_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_with_rsp();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = NOP;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    #1;
    checks++; if (pc_wen !== 1'b1 || pc_wdata !== 64'h8000_2000) begin errors++; $display("FAIL rdr_pcw: got wen=%b wdata=%h want 1 80002000", pc_wen, pc_wdata); end
    tick();
    drive_idle();
    #1;
    checks++; if (inst_valid !== 1'b0 || dbg_state !== REQ || imem_req_addr !== 64'h8000_2000) begin errors++; $display("FAIL rdr_next: got iv=%b st=%0d addr=%h want 0 %0d 80002000", inst_valid, dbg_state, imem_req_addr, REQ); end
  endtask

  task automatic test_fetch_err();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0008;
    #1;
    checks++; if (pc_wen !== 1'b1 || pc_wdata !== 64'h8000_0008 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL err_withdraw: got wen=%b wdata=%h req=%b want 1 80000008 1", pc_wen, pc_wdata, imem_req_valid); end
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    checks++; if (dbg_state !== REQ || imem_req_addr !== 64'h8000_0008) begin errors++; $display("FAIL err_req: got st=%0d addr=%h want %0d 80000008", dbg_state, imem_req_addr, REQ); end
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (pc_wen !== 1'b1 || pc_wdata !== 64'h8000_000C) begin errors++; $display("FAIL err_pcw: got wen=%b wdata=%h want 1 8000000c", pc_wen, pc_wdata); end
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_err !== 1'b1 || inst_pc !== 64'h8000_0008 || inst !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_inst: got v=%b err=%b pc=%h inst=%h want 1 1 80000008 deadbeef", inst_valid, inst_err, inst_pc, inst); end
  endtask

  task automatic test_hold_redirect();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE; inst_ready = 1'b1;
    #1;
    checks++; if (pc_wen !== 1'b1 || pc_wdata !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL hrd_pcw: got wen=%b wdata=%h want 1 fffffffffffffffc", pc_wen, pc_wdata); end
    tick();
    drive_idle();
    #1;
    checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL hrd_next: got iv=%b req=%b addr=%h want 0 1 fffffffffffffffc", inst_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = NOP;
    #1;
    checks++; if (pc_wen !== 1'b1 || pc_wdata !== 64'h0) begin errors++; $display("FAIL wrap_pcw: got wen=%b wdata=%h want 1 0", pc_wen, pc_wdata); end
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    checks++; if (inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC || inst_valid !== 1'b1) begin errors++; $display("FAIL wrap_inst_pc: got v=%b pc=%h want 1 fffffffffffffffc", inst_valid, inst_pc); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin errors++; $display("FAIL wrap_req: got v=%b addr=%h want 1 0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_mid();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; reset = 1'b1;
    tick();
    #1;
    checks++; if ({inst_valid, imem_req_valid, pc_wen} !== 3'b000 || dbg_state !== IDLE) begin errors++; $display("FAIL rst_mid: got v=%b st=%0d want 000 %0d", {inst_valid, imem_req_valid, pc_wen}, dbg_state, IDLE); end
    checks++; if (inst !== '0 || inst_pc !== '0 || inst_err !== 1'b0) begin errors++; $display("FAIL rst_mid_regs: got inst=%h pc=%h err=%b want 0", inst, inst_pc, inst_err); end
    reset = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = NOP;
    redirect_valid = 1'b1; redirect_pc = 64'h1000;
    #1;
    checks++; if (pc_wen !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_late_rsp: got wen=%b req=%b want 0 0", pc_wen, imem_req_valid); end
    tick();
    drive_idle();
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || inst_valid !== 1'b0) begin errors++; $display("FAIL rst_restart: got req=%b addr=%h iv=%b want 1 80000000 0", imem_req_valid, imem_req_addr, inst_valid); end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_with_rsp();
    test_fetch_err();
    test_hold_redirect();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
